// File: rtl/and_mon_pkg.sv
// Shared defaults and sizing helpers for the AND group monitor.
// Build with AND_MON_COUNT_EN defined to include the event counter.
package and_mon_pkg;

  localparam int DEF_NUM_GROUPS  = 4;
  localparam int DEF_GROUP_WIDTH = 2;
  localparam int DEF_FILT_CYCLES = 3;
  localparam int DEF_CNT_W       = 8;

  function automatic int fc_width(input int f);
    return ($clog2(f) < 1) ? 1 : $clog2(f);
  endfunction

  function automatic longint unsigned sat_max(
    input int w
  );
    if (w >= 64)
      return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/and_mon_filter.sv
// One AND group: two-flop synchroniser, reduction,
// glitch filter and rise/sticky flags.
module and_mon_filter
  import and_mon_pkg::*;
#(
  parameter int GW   = DEF_GROUP_WIDTH,
  parameter int FILT = DEF_FILT_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          clr,
  input  logic [GW-1:0] in_bits,
  output logic          o_and,
  output logic          o_and_nxt,
  output logic          o_rise,
  output logic          o_sticky
);

  localparam int FW = fc_width(FILT);
  localparam logic [FW-1:0] FC_LAST = FW'(FILT - 1);

  logic [GW-1:0] r_sync1;
  logic [GW-1:0] r_sync2;
  logic [FW-1:0] r_fc;
  logic          r_and;
  logic          r_rise;
  logic          r_sticky;

  logic          w_raw;
  logic [FW-1:0] w_fc_nxt;
  logic          w_and_nxt;
  logic          w_rise_nxt;

  assign w_raw = &r_sync2;

  always_comb begin
    w_fc_nxt  = r_fc;
    w_and_nxt = r_and;
    if (ena) begin
      if (w_raw != r_and) begin
        if (r_fc == FC_LAST) begin
          w_and_nxt = ~r_and;
          w_fc_nxt  = '0;
        end else begin
          w_fc_nxt = r_fc + FW'(1);
        end
      end else begin
        w_fc_nxt = '0;
      end
    end
  end

  // Held level when ena is low, so no rise can be seen.
  assign w_rise_nxt = w_and_nxt & ~r_and;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_fc     <= '0;
      r_and    <= 1'b0;
      r_rise   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_sync1  <= in_bits;
      r_sync2  <= r_sync1;
      r_fc     <= w_fc_nxt;
      r_and    <= w_and_nxt;
      r_rise   <= w_rise_nxt;
      r_sticky <= w_rise_nxt | (r_sticky & ~clr);
    end
  end

  assign o_and     = r_and;
  assign o_and_nxt = w_and_nxt;
  assign o_rise    = r_rise;
  assign o_sticky  = r_sticky;

endmodule

// File: rtl/and_group_monitor.sv
// Grouped AND monitor with filtered levels, pulses and sticky flags.
// AND_MON_COUNT_EN adds the saturating all_and rise counter.
module and_group_monitor
  import and_mon_pkg::*;
#(
  parameter int NUM_GROUPS  = DEF_NUM_GROUPS,
  parameter int GROUP_WIDTH = DEF_GROUP_WIDTH,
  parameter int FILT_CYCLES = DEF_FILT_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ena,
  input  logic [NUM_GROUPS*GROUP_WIDTH-1:0] in_vec,
  input  logic                            clr,
  output logic [NUM_GROUPS-1:0]           grp_and,
  output logic                            all_and,
  output logic [NUM_GROUPS-1:0]           grp_rise,
  output logic [NUM_GROUPS-1:0]           sticky,
  output logic [CNT_W-1:0]                evt_cnt
);

  logic [NUM_GROUPS-1:0] w_and;
  logic [NUM_GROUPS-1:0] w_and_nxt;
  logic [NUM_GROUPS-1:0] w_rise;
  logic [NUM_GROUPS-1:0] w_sticky;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    and_mon_filter #(
      .GW   (GROUP_WIDTH),
      .FILT (FILT_CYCLES)
    ) u_filt (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .clr       (clr),
      .in_bits   (in_vec[g*GROUP_WIDTH +: GROUP_WIDTH]),
      .o_and     (w_and[g]),
      .o_and_nxt (w_and_nxt[g]),
      .o_rise    (w_rise[g]),
      .o_sticky  (w_sticky[g])
    );
  end

  assign grp_and  = w_and;
  assign grp_rise = w_rise;
  assign sticky   = w_sticky;
  assign all_and  = &w_and;

`ifdef AND_MON_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(sat_max(CNT_W));

  logic             w_all_nxt;
  logic             w_all_rise;
  logic [CNT_W-1:0] r_cnt;

  // Look ahead one edge so the count lands with grp_and.
  assign w_all_nxt  = &w_and_nxt;
  assign w_all_rise = w_all_nxt & ~all_and;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= w_all_rise ? CNT_W'(1) : '0;
    end else if (w_all_rise && r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign evt_cnt = r_cnt;
`else
  assign evt_cnt = '0;
`endif

endmodule

// File: tb/tb_and_group_monitor.sv
// Directed scoreboard bench for and_group_monitor at default
// parameters, plus a CNT_W=2 copy sharing stimulus for saturation.
module tb_and_group_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       clr;
  logic [7:0] in_vec;

  logic [3:0] grp_and,  grp_and2;
  logic       all_and,  all_and2;
  logic [3:0] grp_rise, grp_rise2;
  logic [3:0] sticky,   sticky2;
  logic [7:0] evt_cnt;
  logic [1:0] evt_cnt2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [3:0] ga;
    logic [3:0] rise;
    logic [3:0] st;
    int         c;
    int         c2;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  and_group_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .in_vec   (in_vec),
    .clr      (clr),
    .grp_and  (grp_and),
    .all_and  (all_and),
    .grp_rise (grp_rise),
    .sticky   (sticky),
    .evt_cnt  (evt_cnt)
  );

  and_group_monitor #(.CNT_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .in_vec   (in_vec),
    .clr      (clr),
    .grp_and  (grp_and2),
    .all_and  (all_and2),
    .grp_rise (grp_rise2),
    .sticky   (sticky2),
    .evt_cnt  (evt_cnt2)
  );

  function automatic int ec(input int v);
`ifdef AND_MON_COUNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input string fld,
                     input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h",
             tag, fld, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [3:0] ga,
                      input logic [3:0] rise, input logic [3:0] st,
                      input int c, input int c2);
    exp_t e;
    e.tag = tag; e.ga = ga; e.rise = rise; e.st = st;
    e.c = ec(c); e.c2 = ec(c2);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "grp_and",  int'(grp_and),  int'(e.ga));
    chk(e.tag, "all_and",  int'(all_and),  int'(&e.ga));
    chk(e.tag, "grp_rise", int'(grp_rise), int'(e.rise));
    chk(e.tag, "sticky",   int'(sticky),   int'(e.st));
    chk(e.tag, "evt_cnt",  int'(evt_cnt),  e.c);
    chk(e.tag, "grp_and2", int'(grp_and2), int'(e.ga));
    chk(e.tag, "evt_cnt2", int'(evt_cnt2), e.c2);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; clr = 1'b0; in_vec = 8'hFF;
    step(3);
    push("reset", 4'h0, 4'h0, 4'h0, 0, 0);
    pop_check();

    // release: filtered level appears on the 5th edge
    rst = 1'b0;
    push("rel_e4", 4'h0, 4'h0, 4'h0, 0, 0);
    push("rel_e5", 4'hF, 4'hF, 4'hF, 1, 1);
    push("rel_e6", 4'hF, 4'h0, 4'hF, 1, 1);
    step(4); pop_check();
    step(1); pop_check();
    step(1); pop_check();

    // counter and CNT_W=2 saturation
    in_vec = 8'h00; push("lo1", 4'h0, 4'h0, 4'hF, 1, 1);
    step(10); pop_check();
    in_vec = 8'hFF; push("hi2", 4'hF, 4'h0, 4'hF, 2, 2);
    step(10); pop_check();
    in_vec = 8'h00; step(10);
    in_vec = 8'hFF; push("hi3", 4'hF, 4'h0, 4'hF, 3, 3);
    step(10); pop_check();
    in_vec = 8'h00; step(10);
    in_vec = 8'hFF; step(10);
    in_vec = 8'h00; step(10);
    in_vec = 8'hFF; push("sat", 4'hF, 4'h0, 4'hF, 5, 3);
    step(10); pop_check();
    in_vec = 8'h00; step(10);
    pulse_clr();
    push("clr", 4'h0, 4'h0, 4'h0, 0, 0);
    pop_check();

    // two-cycle glitch is filtered out
    in_vec = 8'h03; step(2);
    in_vec = 8'h00;
    push("glitch", 4'h0, 4'h0, 4'h0, 0, 0);
    step(10); pop_check();

    // three-cycle pulse just passes
    in_vec = 8'h03; step(3);
    in_vec = 8'h00;
    push("pulse3", 4'h1, 4'h1, 4'h1, 0, 0);
    push("pulse3_end", 4'h0, 4'h0, 4'h1, 0, 0);
    step(2); pop_check();
    step(8); pop_check();
    pulse_clr();

    // group isolation
    in_vec = 8'h0C;
    push("iso_e5", 4'h2, 4'h2, 4'h2, 0, 0);
    push("iso", 4'h2, 4'h0, 4'h2, 0, 0);
    step(5); pop_check();
    step(5); pop_check();

    // clr on the edge that completes all_and
    in_vec = 8'hFC; step(10);
    pulse_clr();
    in_vec = 8'hFF; step(4);
    clr = 1'b1;
    push("clr_coll", 4'hF, 4'h1, 4'h1, 1, 1);
    step(1); pop_check();
    clr = 1'b0;

    // ena freeze mid-count
    in_vec = 8'h00; step(10);
    in_vec = 8'hFF; step(4);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push("frozen", 4'h0, 4'h0, 4'h1, 1, 1);
      step(1); pop_check();
    end
    ena = 1'b1;
    push("resume", 4'hF, 4'hF, 4'hF, 2, 2);
    step(1); pop_check();

    // reset mid-filter clears at once
    in_vec = 8'h00; step(4);
    rst = 1'b1; #1;
    push("rst_mid", 4'h0, 4'h0, 4'h0, 0, 0);
    pop_check();
    rst = 1'b0;
    push("rst_after", 4'h0, 4'h0, 4'h0, 0, 0);
    step(8); pop_check();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/and_group_monitor.md
# and_group_monitor

Parametrised, registered successor to the fixed 2-input/8-input AND demo. Partitions a wide input vector into equal groups, synchronises and AND-reduces each group, filters glitches, and reports per-group levels, rising-edge pulses, sticky flags, a global AND and, optionally, a saturating event count. Sits directly behind the dedicated input pins, inside the top-level wrapper.

## Interface
- NUM_GROUPS, 4, number of AND groups (≥1)
- GROUP_WIDTH, 2, inputs per group (≥1)
- FILT_CYCLES, 3, consecutive stable cycles needed to change a filtered level (≥1)
- CNT_W, 8, event counter width (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ena  in  1  enable; low freezes filter, flags and counter
- in_vec  in  NUM_GROUPS*GROUP_WIDTH  raw inputs; group g = in_vec[g*GROUP_WIDTH +: GROUP_WIDTH]
- clr  in  1  synchronous clear of sticky and evt_cnt
- grp_and  out  NUM_GROUPS  filtered AND per group
- all_and  out  1  AND of all grp_and bits
- grp_rise  out  NUM_GROUPS  one-cycle pulse on grp_and 0→1
- sticky  out  NUM_GROUPS  set on grp_rise, held until clr
- evt_cnt  out  CNT_W  count of all_and 0→1 transitions

## Operation
- Two-flop synchroniser on every in_vec bit; always runs, independent of ena.
- raw[g] = AND of group g's synchronised bits (combinational).
- Per-group filter: counter fc[g]. If ena and raw[g] != grp_and[g]: if fc[g] == FILT_CYCLES-1, toggle grp_and[g] and zero fc[g]; else increment. If raw[g] == grp_and[g], zero fc[g]. If !ena, hold fc and grp_and.
- grp_rise[g] registered, high for exactly the cycle after grp_and[g] rises; 0 whenever ena low.
- sticky[g]: set on the edge grp_and[g] rises; cleared by clr; set beats clr on the same edge.
- all_and = &grp_and, combinational from registers (glitch-free).
- evt_cnt: +1 on the edge all_and goes 0→1; saturates at 2^CNT_W-1; clr zeroes it; a simultaneous rise and clr yields 1. Frozen while ena low.
- Pulses shorter than FILT_CYCLES synchronised cycles never reach grp_and.

## Timing
- Reset: all synchroniser flops, fc, grp_and, grp_rise, sticky, evt_cnt = 0; all_and = 0. Assertion mid-filter discards partial counts immediately.
- Latency: in_vec stable before edge k ⇒ grp_and, grp_rise, sticky, evt_cnt update at edge k+1+FILT_CYCLES (k+4 at defaults); all_and same cycle as grp_and.
- Falling edges use the same latency; no pulse generated.
- ena deasserted mid-count: fc held, resumes on re-enable if mismatch persists.

## Configuration
- AND_MON_COUNT_EN defined: evt_cnt counter present as above.
- Undefined: no counter logic; evt_cnt tied to 0; clr only affects sticky.

## Structure
- Package and_mon_pkg: default parameter constants, fc width function (clog2 of FILT_CYCLES, min 1), counter saturation constant helper.
- Sub-module and_mon_filter: one group's synchroniser, reduction, filter and rise/sticky logic; instantiated NUM_GROUPS times by generate. Top owns all_and and evt_cnt.

## Test plan
- Reset: rst=1 with in_vec=8'hFF → all outputs 0; release, hold 8'hFF → grp_and=4'hF, all_and=1, grp_rise=4'hF for one cycle, 4 edges after release of first sample.
- Glitch: in_vec 8'h00→8'h03 for 2 cycles→8'h00 → grp_and stays 0, no sticky.
- Group isolation: in_vec=8'h0C held → only grp_and[1]=1, sticky=4'h2, all_and=0, evt_cnt=0.
- Counter: toggle all_and high 3 times (8'hFF/8'h00, 10 cycles each) → evt_cnt=3; CNT_W=2 with 5 rises → saturates at 3.
- clr collision: clr asserted on same edge grp_and[0] rises → sticky[0]=1, evt_cnt=1 if that rise completes all_and.
- ena freeze: drop ena after 2 mismatch cycles, hold 5 cycles, re-enable → grp_and changes exactly 1 cycle later; no grp_rise while ena low.
